// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector with registered detect pulse
// and a saturating match counter; resets to an overlapping "11" detector.
module seq_detector_param #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 16,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   output logic               cfg_err,
   input  logic               in_valid,
   input  logic               din,
   input  logic               clr_count,
   output logic               detect,
   output logic [CNT_W-1:0]   match_count
);

   typedef enum logic [1:0] {EMPTY, FILLING, PRIMED} state_t;

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   logic [MAX_LEN-1:0] pat_r, pat_nxt;
   logic [LEN_W-1:0]   len_r, len_nxt;
   logic               ovl_r, ovl_nxt;
   logic [MAX_LEN-1:0] hist, hist_nxt;
   logic [LEN_W-1:0]   fill, fill_nxt;
   logic               detect_nxt, cfg_err_nxt;
   logic [CNT_W-1:0]   count_nxt;

   state_t             state;
   logic [MAX_LEN:0]   window;
   logic [MAX_LEN-1:0] mask;
   logic               cfg_ok, load, match;

   // State register: configuration, history, fill counter and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_r       <= MAX_LEN'(2'b11);
         len_r       <= LEN_W'(2);
         ovl_r       <= 1'b1;
         hist        <= '0;
         fill        <= '0;
         detect      <= 1'b0;
         cfg_err     <= 1'b0;
         match_count <= '0;
      end else begin
         pat_r       <= pat_nxt;
         len_r       <= len_nxt;
         ovl_r       <= ovl_nxt;
         hist        <= hist_nxt;
         fill        <= fill_nxt;
         detect      <= detect_nxt;
         cfg_err     <= cfg_err_nxt;
         match_count <= count_nxt;
      end
   end

   // State decode and match evaluation; window carries the full history so
   // the top bit is masked off rather than sliced away
   always_comb begin
      if (fill >= len_r - LEN_W'(1))
         state = PRIMED;
      else if (fill == '0)
         state = EMPTY;
      else
         state = FILLING;
      cfg_ok = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
      load   = cfg_we && cfg_ok;
      window = {hist, din};
      mask   = {MAX_LEN{1'b1}} >> (MAX_LEN - int'(len_r));
      match  = in_valid && !load && (state == PRIMED) &&
               (((window ^ {1'b0, pat_r}) & {1'b0, mask}) == '0);
   end

   // Next-state logic; a legal config write discards the sample in its cycle
   always_comb begin
      pat_nxt     = pat_r;
      len_nxt     = len_r;
      ovl_nxt     = ovl_r;
      hist_nxt    = hist;
      fill_nxt    = fill;
      detect_nxt  = 1'b0;
      cfg_err_nxt = 1'b0;
      count_nxt   = match_count;
      if (load) begin
         pat_nxt  = cfg_pattern;
         len_nxt  = cfg_len;
         ovl_nxt  = cfg_overlap;
         hist_nxt = '0;
         fill_nxt = '0;
      end else begin
         cfg_err_nxt = cfg_we;
         if (in_valid) begin
            hist_nxt = window[MAX_LEN-1:0];
            fill_nxt = (fill == len_r) ? fill : fill + LEN_W'(1);
            if (match) begin
               detect_nxt = 1'b1;
               if (match_count != '1)
                  count_nxt = match_count + CNT_W'(1);
               if (!ovl_r) begin
                  hist_nxt = '0;
                  fill_nxt = '0;
               end
            end
         end
      end
      if (clr_count)
         count_nxt = '0;
   end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed table-driven bench for seq_detector_param (MAX_LEN=8, CNT_W=4)
// plus hand-written saturation and mid-pattern reset sequences.
module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_we = 1'b0;
   logic [7:0] cfg_pattern = '0;
   logic [3:0] cfg_len = '0;
   logic       cfg_overlap = 1'b0;
   logic       cfg_err;
   logic       in_valid = 1'b0;
   logic       din = 1'b0;
   logic       clr_count = 1'b0;
   logic       detect;
   logic [3:0] match_count;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic       we;
      logic [7:0] pat;
      logic [3:0] len;
      logic       ovl;
      logic       v;
      logic       d;
      logic       clr;
      logic       e_det;
      logic       e_err;
      logic [3:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   seq_detector_param #(.MAX_LEN(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
      .in_valid(in_valid), .din(din), .clr_count(clr_count),
      .detect(detect), .match_count(match_count)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic we, input logic [7:0] pat, input logic [3:0] len,
                               input logic ovl, input logic v, input logic d, input logic clr,
                               input logic e_det, input logic e_err, input logic [3:0] e_cnt);
      vec_t t;
      t.we = we; t.pat = pat; t.len = len; t.ovl = ovl; t.v = v; t.d = d; t.clr = clr;
      t.e_det = e_det; t.e_err = e_err; t.e_cnt = e_cnt;
      return t;
   endfunction

   // Sample data row: no config write
   function automatic vec_t smp(input logic v, input logic d, input logic clr,
                                input logic e_det, input logic [3:0] e_cnt);
      return mk(1'b0, 8'h00, 4'd0, 1'b0, v, d, clr, e_det, 1'b0, e_cnt);
   endfunction

   task automatic applyStimulus(input vec_t t);
      @(negedge clk);
      cfg_we      = t.we;
      cfg_pattern = t.pat;
      cfg_len     = t.len;
      cfg_overlap = t.ovl;
      in_valid    = t.v;
      din         = t.d;
      clr_count   = t.clr;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic e_det, input logic e_err,
                              input logic [3:0] e_cnt);
      checks++;
      if (detect !== e_det || cfg_err !== e_err || match_count !== e_cnt) begin
         failures++;
         $display("[TB] FAIL %s: got detect=%b cfg_err=%b count=%0d, want detect=%b cfg_err=%b count=%0d",
                  name, detect, cfg_err, match_count, e_det, e_err, e_cnt);
      end
   endtask

   task automatic setIdle();
      cfg_we = 1'b0; in_valid = 1'b0; din = 1'b0; clr_count = 1'b0;
   endtask

   initial begin
      // Reset defaults: overlapping "11"
      vecs.push_back(smp(1, 1, 0, 0, 0));
      vecs.push_back(smp(1, 1, 0, 1, 1));
      vecs.push_back(smp(1, 1, 0, 1, 2));
      vecs.push_back(smp(1, 0, 0, 0, 2));
      vecs.push_back(smp(1, 1, 0, 0, 2));
      vecs.push_back(smp(1, 1, 0, 1, 3));
      vecs.push_back(smp(0, 1, 1, 0, 0));
      // 1011 overlapping; the sample in the write cycle is discarded
      vecs.push_back(mk(1, 8'b1011, 4, 1, 1, 1, 0, 0, 0, 0));
      vecs.push_back(smp(1, 1, 0, 0, 0));
      vecs.push_back(smp(1, 0, 0, 0, 0));
      vecs.push_back(smp(1, 1, 0, 0, 0));
      vecs.push_back(smp(1, 1, 0, 1, 1));
      vecs.push_back(smp(1, 0, 0, 0, 1));
      vecs.push_back(smp(1, 1, 0, 0, 1));
      vecs.push_back(smp(1, 1, 0, 1, 2));
      vecs.push_back(smp(0, 1, 0, 0, 2));
      vecs.push_back(smp(0, 0, 1, 0, 0));
      // 1011 non-overlapping
      vecs.push_back(mk(1, 8'b1011, 4, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(smp(1, 1, 0, 0, 0));
      vecs.push_back(smp(1, 0, 0, 0, 0));
      vecs.push_back(smp(1, 1, 0, 0, 0));
      vecs.push_back(smp(1, 1, 0, 1, 1));
      vecs.push_back(smp(1, 0, 0, 0, 1));
      vecs.push_back(smp(1, 1, 0, 0, 1));
      vecs.push_back(smp(1, 1, 0, 0, 1));
      vecs.push_back(smp(0, 0, 1, 0, 0));
      // 101 with three invalid cycles between bits
      vecs.push_back(mk(1, 8'b101, 3, 1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(smp(1, 1, 0, 0, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(smp(0, 1, 0, 0, 0));
      vecs.push_back(smp(1, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(smp(0, 1, 0, 0, 0));
      vecs.push_back(smp(1, 1, 0, 1, 1));
      vecs.push_back(smp(0, 1, 0, 0, 1));
      vecs.push_back(smp(0, 0, 1, 0, 0));
      // Illegal lengths: error pulse, sample still processed, config kept
      vecs.push_back(smp(1, 1, 0, 0, 0));
      vecs.push_back(smp(1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'hFF, 0, 0, 1, 1, 0, 1, 1, 1));
      vecs.push_back(mk(1, 8'hFF, 9, 0, 1, 0, 0, 0, 1, 1));
      vecs.push_back(smp(1, 1, 0, 1, 2));
      // Legal reprogram mid-pattern must not match on stale history
      vecs.push_back(smp(1, 0, 0, 0, 2));
      vecs.push_back(mk(1, 8'b101, 3, 1, 1, 1, 0, 0, 0, 2));
      vecs.push_back(smp(1, 1, 0, 0, 2));
      vecs.push_back(smp(1, 0, 0, 0, 2));
      vecs.push_back(smp(1, 1, 0, 1, 3));
      vecs.push_back(smp(0, 0, 1, 0, 0));
      // Length 1, pattern 0, non-overlapping: back-to-back matches
      vecs.push_back(mk(1, 8'hFE, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(smp(1, 0, 0, 1, 1));
      vecs.push_back(smp(1, 0, 0, 1, 2));
      vecs.push_back(smp(1, 1, 0, 0, 2));
      vecs.push_back(smp(1, 0, 0, 1, 3));
      vecs.push_back(smp(0, 0, 1, 0, 0));

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_state", 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d", i), vecs[i].e_det, vecs[i].e_err, vecs[i].e_cnt);
      end

      // Saturation with length-1 pattern "1"
      applyStimulus(mk(1, 8'h01, 1, 1, 0, 0, 0, 0, 0, 0));
      checkOutput("sat_cfg", 1'b0, 1'b0, 4'd0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(smp(1, 1, 0, 1, 0));
         checkOutput($sformatf("sat%0d", i), 1'b1, 1'b0, (i + 1 > 15) ? 4'd15 : 4'(i + 1));
      end
      applyStimulus(smp(1, 1, 1, 1, 0));
      checkOutput("clr_with_match", 1'b1, 1'b0, 4'd0);
      applyStimulus(smp(1, 1, 0, 1, 1));
      checkOutput("match_after_clr", 1'b1, 1'b0, 4'd1);

      // Asynchronous reset mid-cycle restores defaults and clears history
      @(negedge clk);
      #2 rst = 1'b1;
      #1 checkOutput("async_reset", 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      rst = 1'b0;
      setIdle();
      applyStimulus(smp(1, 1, 0, 0, 0));
      checkOutput("post_reset_first", 1'b0, 1'b0, 4'd0);
      applyStimulus(smp(1, 1, 0, 1, 1));
      checkOutput("post_reset_match", 1'b1, 1'b0, 4'd1);
      applyStimulus(smp(0, 1, 0, 0, 1));
      checkOutput("post_reset_idle", 1'b0, 1'b0, 4'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector, the successor to the fixed "11" detector. The pattern, its length and the overlap mode are programmable at run time. It produces a one-cycle registered detect pulse and a saturating match counter. It sits on a serial data path behind a valid qualifier, and status goes to a register block.

## Interface
Parameters:
- MAX_LEN, 8, longest supported pattern in bits (legal range 2..32).
- CNT_W, 16, match counter width.
- LEN_W, $clog2(MAX_LEN+1), width of the length field (derived; do not override).

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  load cfg_pattern/cfg_len/cfg_overlap into the active configuration.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is matched against the oldest sample, bit 0 against the newest.
- cfg_len  in  LEN_W  pattern length; legal range is 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_err  out  1  one-cycle pulse when cfg_we carries an illegal cfg_len.
- in_valid  in  1  din is sampled only when this is high.
- din  in  1  serial data bit.
- clr_count  in  1  synchronous clear of match_count.
- detect  out  1  one-cycle pulse: the pattern completed on the previous accepted sample.
- match_count  out  CNT_W  number of detections, saturating at all-ones.

## Operation
- Active configuration registers: pat_r, len_r, ovl_r. Reset values are pat_r = 2'b11 (zero-extended), len_r = 2, ovl_r = 1, so after reset the block behaves as an overlapping "11" detector.
- History register hist[MAX_LEN-1:0] shifts left on each accepted sample: hist <= {hist[MAX_LEN-2:0], din}.
- Fill counter fill (0..len_r) forms the state machine:
  - EMPTY: fill = 0.
  - FILLING: 0 < fill < len_r-1.
  - PRIMED: fill >= len_r-1.
  - fill increments on each accepted sample and saturates at len_r.
- Match condition, evaluated combinationally on an accepted sample: in_valid, state PRIMED, and the low len_r bits of {hist[MAX_LEN-2:0], din} equal the low len_r bits of pat_r.
- On a match:
  - detect <= 1.
  - match_count increments unless it is already all-ones.
  - If ovl_r = 1, fill saturates and detection continues, so overlapping matches are counted.
  - If ovl_r = 0, fill <= 0 and hist <= 0; the next match needs len_r fresh samples.
- When in_valid = 0, hist, fill and match_count hold, and detect <= 0.
- cfg_we with 1 <= cfg_len <= MAX_LEN:
  - Registers are loaded.
  - hist <= 0, fill <= 0, detect <= 0.
  - Any in_valid sample in that cycle is discarded.
  - match_count is retained.
- cfg_we with cfg_len = 0 or cfg_len > MAX_LEN: cfg_err <= 1 for one cycle. Configuration, hist and fill are unchanged, and the sample in that cycle is processed normally.
- len_r = 1: every accepted sample equal to pat_r[0] matches, including back-to-back samples, regardless of ovl_r.
- clr_count: match_count <= 0. If a match occurs in the same cycle, clear wins (count = 0) but detect still pulses.
- Unused pattern bits above len_r-1 are ignored.

## Timing
- Reset values: detect = 0, cfg_err = 0, match_count = 0, hist = 0, fill = 0, configuration as listed above.
- Reset is asynchronous; asserting it mid-pattern discards partial history immediately.
- Latency: detect is high in the cycle after the clock edge that accepts the completing sample, for exactly one cycle per match. It is never combinational from din.
- match_count updates on the same edge that sets detect.
- cfg_err is high in the cycle after the rejected cfg_we edge.
- Continuous in_valid sustains one accepted sample per cycle; there is no backpressure.

## Test plan
- Reset defaults: din = 1,1,1,0,1,1 with in_valid = 1 → detect high after samples 2, 3 and 6; match_count = 3.
- Program pattern 1011, len 4, ovl 1; stream 1011011 → detects after samples 4 and 7; count = 2.
- Same stream with ovl 0 → single detect after sample 4; count = 1.
- Gapped valid: pattern 101 with in_valid low for 3 cycles between each bit → one detect; detect is never high while in_valid is low.
- cfg_len = 0, then cfg_len = MAX_LEN+1 → cfg_err pulses twice and detection of the prior pattern is uninterrupted; reprogramming mid-pattern with a legal config → no false detect from stale history.
- CNT_W = 4: 20 matches → count saturates at 15; clr_count coincident with a match → count 0 and detect = 1; rst asserted mid-pattern → all outputs 0 and the next detect requires a full pattern.
